// File: rtl/tt_sweep_pkg.sv
// Shared types and default sizing for the truth-table sweeper.
package tt_sweep_pkg;

    localparam int N_IN_DEF  = 7;
    localparam int TT_W_DEF  = 2 ** N_IN_DEF;
    localparam int CNT_W_DEF = N_IN_DEF + 1;
    localparam int IDX_W_DEF = N_IN_DEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/tt_cmp_acc.sv
// Per-bit compare of a captured function output against the expected table,
// with a saturating mismatch counter and lowest-mismatch-index capture.
module tt_cmp_acc
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int TT_W = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            vld,
    input  logic            f_bit,
    input  logic            exp_bit,
    input  logic [N_IN-1:0] idx,
    output logic [N_IN:0]   mism_cnt,
    output logic [N_IN-1:0] first_mism,
    output logic            zero_nxt
);

    localparam int CNT_W = N_IN + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]  first_q, first_d;
    logic             mism;

    // Next-state of the counter and first-mismatch index for the bit being stored.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d   = cnt_q;
        first_d = first_q;
        mism    = vld && (f_bit != exp_bit);
        if (clr) begin
            cnt_d   = '0;
            first_d = '0;
        end else if (mism) begin
            if (cnt_q == '0) begin
                first_d = idx;
            end
            if (cnt_q != CNT_W'(TT_W)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        zero_nxt = (cnt_d == '0);
    end

    // Counter and index registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            first_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    assign mism_cnt   = cnt_q;
    assign first_mism = first_q;

endmodule

// File: rtl/tt_sweep.sv
// Drives every input combination into a combinational function, records its
// truth table one cycle later, and compares it with an expected table.
module tt_sweep
    import tt_sweep_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int TT_W = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TT_W-1:0] exp_tt,
    input  logic            f_in,
    output logic [N_IN-1:0] x,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt,
    output logic            match,
    output logic [N_IN:0]   mism_cnt,
    output logic [N_IN-1:0] first_mism
);

    localparam logic [N_IN-1:0] X_LAST = N_IN'(TT_W - 1);

    state_e          state_q, state_d;
    logic [N_IN-1:0] x_q, x_d;
    logic [TT_W-1:0] exp_q, exp_d;
    logic [TT_W-1:0] tt_q, tt_d;
    logic            f_q, f_d;
    logic [N_IN-1:0] idx_q, idx_d;
    logic            vld_q, vld_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            match_q, match_d;
    logic            clr;
    logic            zero_nxt;

    // FSM next-state, x counter, and storage of the delayed sample into tt.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        exp_d   = exp_q;
        tt_d    = tt_q;
        f_d     = f_in;
        idx_d   = x_q;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        busy_d  = busy_q;
        match_d = match_q;
        clr     = 1'b0;

        // The bit sampled last cycle belongs to the x presented the cycle before.
        if (vld_q) begin
            tt_d[idx_q] = f_q;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                x_d    = '0;
                busy_d = 1'b0;
                if (start) begin
                    state_d = ST_DRIVE;
                    exp_d   = exp_tt;
                    tt_d    = '0;
                    clr     = 1'b1;
                    match_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_DRIVE: begin
                vld_d = 1'b1;
                if (x_q == X_LAST) begin
                    state_d = ST_DRAIN;
                    x_d     = '0;
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                match_d = zero_nxt;
            end
            default: begin
                state_d = ST_IDLE;
                x_d     = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Register bank for FSM state, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            f_q     <= 1'b0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            f_q     <= f_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            match_q <= match_d;
        end
    end

    tt_cmp_acc #(
        .N_IN (N_IN),
        .TT_W (TT_W)
    ) u_cmp_acc (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .vld        (vld_q),
        .f_bit      (f_q),
        .exp_bit    (exp_q[idx_q]),
        .idx        (idx_q),
        .mism_cnt   (mism_cnt),
        .first_mism (first_mism),
        .zero_nxt   (zero_nxt)
    );

    assign x     = x_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign tt    = tt_q;
    assign match = match_q;

endmodule

// File: tb/tb_tt_sweep.sv
// Directed bench for tt_sweep: several functions under test, reset abort,
// ignored start while busy, back-to-back start in the done cycle.
module tb_tt_sweep;

    localparam int N_IN = 7;
    localparam int TT_W = 128;

    localparam logic [127:0] TT_MAJ = {16{8'hE8}};
    localparam logic [127:0] TT_X6  = 128'hFFFFFFFFFFFFFFFF0000000000000000;
    localparam logic [127:0] TT_XOR = {64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA};

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [TT_W-1:0] exp_tt;
    logic            f_in;
    logic [N_IN-1:0] x;
    logic            busy;
    logic            done;
    logic [TT_W-1:0] tt;
    logic            match;
    logic [N_IN:0]   mism_cnt;
    logic [N_IN-1:0] first_mism;

    int mode;
    int n_vec = 0;
    int n_mis = 0;

    tt_sweep #(.N_IN(N_IN)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .exp_tt     (exp_tt),
        .f_in       (f_in),
        .x          (x),
        .busy       (busy),
        .done       (done),
        .tt         (tt),
        .match      (match),
        .mism_cnt   (mism_cnt),
        .first_mism (first_mism)
    );

    always #5 clk = ~clk;

    // Function under test, selected by mode.
    always_comb begin
        case (mode)
            0:       f_in = (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
            1:       f_in = x[6];
            2:       f_in = 1'b0;
            default: f_in = x[0] ^ x[6];
        endcase
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge: present start for one edge with the given table.
    task automatic launch(input logic [127:0] e);
        start  = 1'b1;
        exp_tt = e;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Counts edges from the accept edge (counted as 1) until done is seen.
    task automatic wait_done(output int lat);
        bit found;
        found = 1'b0;
        lat   = 1;
        for (int i = 0; i < 300 && !found; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done) found = 1'b1;
        end
        if (!found) lat = -1;
    endtask

    task automatic wait_x(input int v, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (x == N_IN'(v)) found = 1'b1;
            else @(negedge clk);
        end
        check(tag, 128'(found), 128'd1);
    endtask

    task automatic check_res(input string tag, input logic [127:0] t, input logic m,
                             input int cnt, input int first);
        check({tag, "_tt"},    tt,         t);
        check({tag, "_match"}, 128'(match), 128'(m));
        check({tag, "_cnt"},   128'(mism_cnt), 128'(cnt));
        check({tag, "_first"}, 128'(first_mism), 128'(first));
        check({tag, "_x0"},    128'(x),    128'd0);
        check({tag, "_busy"},  128'(busy), 128'd0);
    endtask

    initial begin
        int  lat;
        bit  saw_done;

        rst    = 1'b1;
        start  = 1'b0;
        exp_tt = '0;
        mode   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state.
        check("rst_busy",  128'(busy), 128'd0);
        check("rst_done",  128'(done), 128'd0);
        check("rst_x",     128'(x),    128'd0);
        check("rst_tt",    tt,         128'd0);
        check("rst_match", 128'(match), 128'd0);
        check("rst_cnt",   128'(mism_cnt), 128'd0);
        check("rst_first", 128'(first_mism), 128'd0);

        // Majority of x0..x2 against its correct table.
        mode = 0;
        launch(TT_MAJ);
        check("maj_busy", 128'(busy), 128'd1);
        wait_done(lat);
        check("maj_lat", 128'(lat), 128'd130);
        check_res("maj", TT_MAJ, 1'b1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        check("maj_done_pulse", 128'(done), 128'd0);
        check("maj_tt_hold", tt, TT_MAJ);
        check("maj_match_hold", 128'(match), 128'd1);

        // f = x6 against all zeros.
        mode = 1;
        launch(128'd0);
        wait_done(lat);
        check("x6_lat", 128'(lat), 128'd130);
        check_res("x6", TT_X6, 1'b0, 64, 64);

        // Constant 0 against a single set bit, then rerun with a clean table.
        mode = 2;
        launch(128'h1);
        wait_done(lat);
        check_res("c0", 128'd0, 1'b0, 1, 0);
        @(negedge clk);
        launch(128'd0);
        wait_done(lat);
        check("c0b_lat", 128'(lat), 128'd130);
        check_res("c0b", 128'd0, 1'b1, 0, 0);

        // Reset at x=50 together with a start: abort, no done.
        mode = 0;
        @(negedge clk);
        launch(TT_MAJ);
        wait_x(50, "ab_reach50");
        rst   = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("ab_busy",  128'(busy), 128'd0);
        check("ab_done",  128'(done), 128'd0);
        check("ab_x",     128'(x),    128'd0);
        check("ab_tt",    tt,         128'd0);
        check("ab_match", 128'(match), 128'd0);
        check("ab_cnt",   128'(mism_cnt), 128'd0);
        check("ab_first", 128'(first_mism), 128'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (done || busy || x != '0) saw_done = 1'b1;
        end
        check("ab_quiet", 128'(saw_done), 128'd0);
        launch(TT_MAJ);
        wait_done(lat);
        check("ab2_lat", 128'(lat), 128'd130);
        check_res("ab2", TT_MAJ, 1'b1, 0, 0);

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        launch(TT_MAJ);
        wait_x(10, "ig_reach10");
        start  = 1'b1;
        exp_tt = '1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        check("ig_x", 128'(x), 128'd11);
        check("ig_busy", 128'(busy), 128'd1);
        saw_done = 1'b0;
        for (int i = 0; i < 300 && !saw_done; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("ig_done_seen", 128'(saw_done), 128'd1);
        check_res("ig", TT_MAJ, 1'b1, 0, 0);
        launch(128'd0);
        check("b2b_tt_clr", tt, 128'd0);
        check("b2b_match_clr", 128'(match), 128'd0);
        check("b2b_busy", 128'(busy), 128'd1);
        wait_done(lat);
        check("b2b_lat", 128'(lat), 128'd130);
        check_res("b2b", TT_MAJ, 1'b0, 64, 3);

        // x0 ^ x6 against the complement of its table: every bit mismatches.
        mode = 3;
        @(negedge clk);
        launch(~TT_XOR);
        wait_done(lat);
        check("sat_lat", 128'(lat), 128'd130);
        check_res("sat", TT_XOR, 1'b0, 128, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
